// File: rtl/obi_2_axi_pipe_pkg.sv
// rtl/obi_2_axi_pipe_pkg.sv - AXI4 channel structs used by obi_2_axi_pipe
package obi_2_axi_pipe_pkg;

    localparam int unsigned AXI_IDW   = 4;
    localparam int unsigned AXI_ADDRW = 32;
    localparam int unsigned AXI_DATAW = 32;
    localparam int unsigned AXI_STRBW = AXI_DATAW / 8;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef logic [AXI_IDW-1:0] axi_id_t;

    typedef struct packed {
        axi_id_t                id;
        logic [AXI_ADDRW-1:0]   addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic                   lock;
        logic [3:0]             cache;
        logic [2:0]             prot;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DATAW-1:0]   data;
        logic [AXI_STRBW-1:0]   strb;
        logic                   last;
    } axi_w_t;

    typedef struct packed {
        axi_id_t                id;
        logic [1:0]             resp;
    } axi_b_t;

    typedef struct packed {
        axi_id_t                id;
        logic [AXI_DATAW-1:0]   data;
        logic [1:0]             resp;
        logic                   last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t                aw;
        logic                   aw_valid;
        axi_w_t                 w;
        logic                   w_valid;
        logic                   b_ready;
        axi_ax_t                ar;
        logic                   ar_valid;
        logic                   r_ready;
    } axi_req_t;

    typedef struct packed {
        logic                   aw_ready;
        logic                   w_ready;
        axi_b_t                 b;
        logic                   b_valid;
        logic                   ar_ready;
        axi_r_t                 r;
        logic                   r_valid;
    } axi_resp_t;

endpackage

// File: rtl/obi_2_axi_pipe.sv
// rtl/obi_2_axi_pipe.sv - pipelined OBI to AXI4 bridge with in-order responses
// Optional feature macro: OBI_2_AXI_PIPE_ERR_RESP_EN (drive err_o from AXI resp[1]).
module obi_2_axi_pipe #(
    parameter int unsigned                OBI_ADDRW       = 32,
    parameter int unsigned                OBI_DATAW       = 32,
    parameter int unsigned                OBI_STRBW       = OBI_DATAW / 8,
    parameter int unsigned                MAX_OUTSTANDING = 4,
    parameter obi_2_axi_pipe_pkg::axi_id_t AXI_ID         = '0,
    parameter type                        axi_req_t       = obi_2_axi_pipe_pkg::axi_req_t,
    parameter type                        axi_resp_t      = obi_2_axi_pipe_pkg::axi_resp_t
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [OBI_ADDRW-1:0] addr_i,
    input  logic                 we_i,
    input  logic [OBI_DATAW-1:0] wdata_i,
    input  logic [OBI_STRBW-1:0] be_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [OBI_DATAW-1:0] rdata_o,
    output logic                 err_o,
    output axi_req_t             axi_req_o,
    input  axi_resp_t            axi_resp_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]  AX_SIZE = 3'($clog2(OBI_STRBW));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [CNT_W-1:0]           cnt_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] order_we_q;

    logic                 ar_valid_q;
    logic                 aw_valid_q;
    logic                 w_valid_q;
    logic [OBI_ADDRW-1:0] ar_addr_q;
    logic [OBI_ADDRW-1:0] aw_addr_q;
    logic [OBI_DATAW-1:0] w_data_q;
    logic [OBI_STRBW-1:0] w_strb_q;
    logic                 rvalid_q;
    logic [OBI_DATAW-1:0] rdata_q;

    logic ar_free;
    logic wr_free;
    logic gnt;
    logic head_valid;
    logic head_we;
    logic r_ready;
    logic b_ready;
    logic r_hs;
    logic b_hs;
    logic rsp_hs;

    // A channel slot is reusable in the cycle its previous beat handshakes.
    assign ar_free = !ar_valid_q || axi_resp_i.ar_ready;
    assign wr_free = (!aw_valid_q || axi_resp_i.aw_ready) && (!w_valid_q || axi_resp_i.w_ready);
    assign gnt     = arst_ni && req_i && (cnt_q < CNT_MAX) && (we_i ? wr_free : ar_free);
    assign gnt_o   = gnt;

    // Only the oldest transaction's channel is allowed to complete.
    assign head_valid = (cnt_q != '0);
    assign head_we    = order_we_q[rd_ptr_q];
    assign r_ready    = head_valid && !head_we;
    assign b_ready    = head_valid && head_we;
    assign r_hs       = r_ready && axi_resp_i.r_valid;
    assign b_hs       = b_ready && axi_resp_i.b_valid;
    assign rsp_hs     = r_hs || b_hs;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            order_we_q <= '0;
        end else begin
            if (gnt && !rsp_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!gnt && rsp_hs) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (gnt) begin
                order_we_q[wr_ptr_q] <= we_i;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rsp_hs) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_addr_q  <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            if (gnt && !we_i) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= addr_i;
            end else if (axi_resp_i.ar_ready) begin
                ar_valid_q <= 1'b0;
            end
            if (gnt && we_i) begin
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
                aw_addr_q  <= addr_i;
                w_data_q   <= wdata_i;
                w_strb_q   <= be_i;
            end else begin
                if (axi_resp_i.aw_ready) aw_valid_q <= 1'b0;
                if (axi_resp_i.w_ready)  w_valid_q  <= 1'b0;
            end
        end
    end

    // An R beat with last=0 is still taken as the only beat of the read.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rsp_hs;
            if (r_hs) begin
                rdata_q <= axi_resp_i.r.data;
            end else if (b_hs) begin
                rdata_q <= '0;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

`ifdef OBI_2_AXI_PIPE_ERR_RESP_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_q <= 1'b0;
        end else if (r_hs) begin
            err_q <= axi_resp_i.r.resp[1];
        end else if (b_hs) begin
            err_q <= axi_resp_i.b.resp[1];
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    logic unused_resp;
    assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.resp,
                           axi_resp_i.r.id, axi_resp_i.r.resp, axi_resp_i.r.last};

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = aw_addr_q;
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = AX_SIZE;
        axi_req_o.aw.burst = obi_2_axi_pipe_pkg::BURST_INCR;
        axi_req_o.aw.cache = 4'b0010;
        axi_req_o.aw.prot  = 3'b000;
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data   = w_data_q;
        axi_req_o.w.strb   = w_strb_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready;
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = ar_addr_q;
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = AX_SIZE;
        axi_req_o.ar.burst = obi_2_axi_pipe_pkg::BURST_INCR;
        axi_req_o.ar.cache = 4'b0010;
        axi_req_o.ar.prot  = 3'b000;
        axi_req_o.ar_valid = ar_valid_q;
        axi_req_o.r_ready  = r_ready;
    end

endmodule

// File: tb/tb_obi_2_axi_pipe.sv
// tb/tb_obi_2_axi_pipe.sv - directed table, corner sequences and random model check of obi_2_axi_pipe
module tb_obi_2_axi_pipe;
    import obi_2_axi_pipe_pkg::*;

    localparam int MAXO = 4;
`ifdef OBI_2_AXI_PIPE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        req_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    axi_req_t    axi_req_o;
    axi_resp_t   axi_resp_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    obi_2_axi_pipe #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .axi_req_o  (axi_req_o),
        .axi_resp_i (axi_resp_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive just after the rising edge, sample one time unit later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        axi_resp_i = '0;
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd;
        logic [1:0]  resp;
        logic        rlast;
        int          aw_dly;
        int          w_dly;
        logic [31:0] exp_rdata;
        logic        exp_err_raw;
        int          exp_k;
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } txn_t;

    task automatic run_vec(input vec_t v);
        logic ar_done, aw_done, w_done, rsp_done;
        int pulses;
        ar_done = 0; aw_done = 0; w_done = 0; rsp_done = 0; pulses = 0;
        cyc();
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
        axi_resp_i = '0;
        settle();
        chk("vec_gnt", gnt_o, 1);
        for (int k = 0; k < 10; k++) begin
            cyc();
            req_i = 1'b0;
            axi_resp_i = '0;
            axi_resp_i.ar_ready = !v.we && !ar_done;
            axi_resp_i.aw_ready = v.we && !aw_done && (k >= v.aw_dly);
            axi_resp_i.w_ready  = v.we && !w_done && (k >= v.w_dly);
            axi_resp_i.r_valid  = !v.we && ar_done && !rsp_done;
            axi_resp_i.r.data   = v.rd;
            axi_resp_i.r.resp   = v.resp;
            axi_resp_i.r.last   = v.rlast;
            axi_resp_i.b_valid  = v.we && aw_done && w_done && !rsp_done;
            axi_resp_i.b.resp   = v.resp;
            settle();
            if (v.we) begin
                chk("vec_no_ar", axi_req_o.ar_valid, 0);
                chk("vec_aw_hold", axi_req_o.aw_valid, !aw_done);
                chk("vec_w_hold", axi_req_o.w_valid, !w_done);
                if (k == 0) begin
                    chk("vec_aw_addr", axi_req_o.aw.addr, v.addr);
                    chk("vec_aw_size", axi_req_o.aw.size, 2);
                    chk("vec_aw_len", axi_req_o.aw.len, 0);
                    chk("vec_w_data", axi_req_o.w.data, v.wdata);
                    chk("vec_w_strb", axi_req_o.w.strb, v.be);
                    chk("vec_w_last", axi_req_o.w.last, 1);
                end
            end else begin
                chk("vec_no_aw_w", axi_req_o.aw_valid | axi_req_o.w_valid, 0);
                if (k == 0) begin
                    chk("vec_ar_valid", axi_req_o.ar_valid, 1);
                    chk("vec_ar_addr", axi_req_o.ar.addr, v.addr);
                    chk("vec_ar_size", axi_req_o.ar.size, 2);
                    chk("vec_ar_len", axi_req_o.ar.len, 0);
                    chk("vec_ar_burst", axi_req_o.ar.burst, 2'b01);
                    chk("vec_ar_cache", axi_req_o.ar.cache, 4'b0010);
                end
            end
            if (rvalid_o) begin
                pulses++;
                chk("vec_rvalid_cycle", k, v.exp_k);
                chk("vec_rdata", rdata_o, v.exp_rdata);
                chk("vec_err", err_o, v.exp_err_raw & ERR_EN);
            end
            if (axi_req_o.ar_valid && axi_resp_i.ar_ready) ar_done = 1;
            if (axi_req_o.aw_valid && axi_resp_i.aw_ready) aw_done = 1;
            if (axi_req_o.w_valid && axi_resp_i.w_ready) w_done = 1;
            if ((axi_req_o.r_ready && axi_resp_i.r_valid) ||
                (axi_req_o.b_ready && axi_resp_i.b_valid)) rsp_done = 1;
        end
        chk("vec_pulses", pulses, 1);
    endtask

    initial begin
        logic [63:0] rnd;
        logic [31:0] sq[$];
        int issued, nresp, nrv;
        logic ar_got, aw_got, w_got, r_done, b_done;

        vecs[0] = '{we:0, addr:32'hAB, wdata:0, be:4'hF, rd:32'h45, resp:2'b00, rlast:1,
                    aw_dly:0, w_dly:0, exp_rdata:32'h45, exp_err_raw:0, exp_k:2};
        vecs[1] = '{we:1, addr:32'hAB, wdata:32'h69, be:4'hF, rd:0, resp:2'b00, rlast:1,
                    aw_dly:3, w_dly:1, exp_rdata:0, exp_err_raw:0, exp_k:5};
        vecs[2] = '{we:0, addr:32'h1000, wdata:0, be:4'hF, rd:32'hDEADBEEF, resp:2'b10, rlast:1,
                    aw_dly:0, w_dly:0, exp_rdata:32'hDEADBEEF, exp_err_raw:1, exp_k:2};
        vecs[3] = '{we:1, addr:32'h2004, wdata:32'h12345678, be:4'b0101, rd:0, resp:2'b11, rlast:1,
                    aw_dly:0, w_dly:2, exp_rdata:0, exp_err_raw:1, exp_k:4};
        vecs[4] = '{we:0, addr:32'h3008, wdata:0, be:4'hF, rd:32'hCAFEF00D, resp:2'b01, rlast:0,
                    aw_dly:0, w_dly:0, exp_rdata:32'hCAFEF00D, exp_err_raw:0, exp_k:2};
        vecs[5] = '{we:1, addr:32'hFFFFFFFC, wdata:32'hA5A5A5A5, be:4'b1000, rd:0, resp:2'b00, rlast:1,
                    aw_dly:0, w_dly:0, exp_rdata:0, exp_err_raw:0, exp_k:2};

        // Reset held with garbage on the AXI response side.
        idle_inputs();
        arst_ni = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            req_i = 1'b1;
            rnd = {$urandom(), $urandom()};
            axi_resp_i = rnd[$bits(axi_resp_t)-1:0];
            settle();
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_axi_valids", {axi_req_o.ar_valid, axi_req_o.aw_valid, axi_req_o.w_valid}, 0);
            chk("rst_axi_readys", {axi_req_o.r_ready, axi_req_o.b_ready}, 0);
        end
        cyc();
        idle_inputs();
        arst_ni = 1'b1;
        settle();
        chk("post_rst_gnt_idle", gnt_o, 0);
        req_i = 1'b1;
        settle();
        chk("post_rst_gnt_follows_req", gnt_o, 1);
        req_i = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Full pipeline: R withheld for 8 cycles while six reads are offered.
        issued = 0; nresp = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            idle_inputs();
            req_i = (issued < 6);
            addr_i = 32'h40 + issued * 4;
            axi_resp_i.ar_ready = 1'b1;
            if (k >= 8 && sq.size() > 0) begin
                axi_resp_i.r_valid = 1'b1;
                axi_resp_i.r.data  = sq[0] + 32'h100;
                axi_resp_i.r.last  = 1'b1;
            end
            settle();
            if (k <= 3) chk("pipe_gnt_burst", gnt_o, 1);
            else if (k <= 8) chk("pipe_gnt_full", gnt_o, 0);
            else if (k == 9) chk("pipe_gnt_after_free", gnt_o, 1);
            if (rvalid_o) begin
                chk("pipe_rdata", rdata_o, 32'h140 + nresp * 4);
                nresp++;
            end
            if (gnt_o) issued++;
            if (axi_req_o.ar_valid && axi_resp_i.ar_ready) sq.push_back(axi_req_o.ar.addr);
            if (axi_req_o.r_ready && axi_resp_i.r_valid) void'(sq.pop_front());
        end
        chk("pipe_nresp", nresp, 6);

        // Reorder: read A then write B, slave offers B long before R.
        ar_got = 0; aw_got = 0; w_got = 0; r_done = 0; b_done = 0; nrv = 0;
        for (int k = 0; k < 14; k++) begin
            cyc();
            idle_inputs();
            if (k == 0) begin req_i = 1'b1; addr_i = 32'h200; end
            if (k == 1) begin req_i = 1'b1; we_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h77; be_i = 4'hF; end
            axi_resp_i.ar_ready = 1'b1;
            axi_resp_i.aw_ready = 1'b1;
            axi_resp_i.w_ready  = 1'b1;
            axi_resp_i.r_valid  = ar_got && !r_done && (k >= 6);
            axi_resp_i.r.data   = 32'hA5A50001;
            axi_resp_i.r.last   = 1'b1;
            axi_resp_i.b_valid  = aw_got && w_got && !b_done;
            settle();
            if (k <= 1) chk("reorder_gnt", gnt_o, 1);
            if (axi_resp_i.b_valid && !r_done) chk("reorder_b_stall", axi_req_o.b_ready, 0);
            if (rvalid_o) begin
                if (nrv == 0) chk("reorder_first_A", rdata_o, 32'hA5A50001);
                else chk("reorder_second_B", rdata_o, 0);
                nrv++;
            end
            if (axi_req_o.ar_valid) ar_got = 1;
            if (axi_req_o.aw_valid) aw_got = 1;
            if (axi_req_o.w_valid) w_got = 1;
            if (axi_req_o.r_ready && axi_resp_i.r_valid) r_done = 1;
            if (axi_req_o.b_ready && axi_resp_i.b_valid) b_done = 1;
        end
        chk("reorder_nrv", nrv, 2);

        // Asynchronous reset with a read in flight.
        cyc();
        idle_inputs();
        req_i = 1'b1; addr_i = 32'h500;
        settle();
        chk("midrst_gnt", gnt_o, 1);
        cyc();
        settle();
        chk("midrst_ar_before", axi_req_o.ar_valid, 1);
        arst_ni = 1'b0;
        #1;
        chk("midrst_ar_cleared", axi_req_o.ar_valid, 0);
        chk("midrst_gnt_low", gnt_o, 0);
        chk("midrst_rdata", rdata_o, 0);
        repeat (2) cyc();
        idle_inputs();
        arst_ni = 1'b1;

        begin : random_test
            txn_t        mq[$];
            logic [31:0] ear[$];
            logic [31:0] eaw[$];
            logic [35:0] ew[$];
            logic [31:0] sar[$];
            logic [31:0] e32;
            logic [35:0] e36;
            int          aw_n, w_n, b_given;
            logic        gnt_seen, r_clr, b_clr, exp_rv, exp_err;
            logic [31:0] exp_rd, last_rd;
            aw_n = 0; w_n = 0; b_given = 0; gnt_seen = 0; r_clr = 0; b_clr = 0;
            exp_rv = 0; exp_err = 0; exp_rd = 0; last_rd = 0;
            for (int k = 0; k < 4000; k++) begin
                cyc();
                if (!req_i || gnt_seen) begin
                    if (k < 3800 && $urandom_range(0, 3) != 0) begin
                        req_i = 1'b1; we_i = $urandom_range(0, 1);
                        addr_i = $urandom(); wdata_i = $urandom(); be_i = 4'($urandom());
                    end else req_i = 1'b0;
                end else if ($urandom_range(0, 7) == 0) req_i = 1'b0;
                axi_resp_i.ar_ready = ($urandom_range(0, 2) != 0);
                axi_resp_i.aw_ready = ($urandom_range(0, 2) != 0);
                axi_resp_i.w_ready  = ($urandom_range(0, 2) != 0);
                if (r_clr) axi_resp_i.r_valid = 1'b0;
                if (b_clr) axi_resp_i.b_valid = 1'b0;
                r_clr = 0; b_clr = 0;
                if (!axi_resp_i.r_valid && sar.size() > 0 && $urandom_range(0, 1) == 1) begin
                    axi_resp_i.r_valid = 1'b1;
                    axi_resp_i.r.data  = hash(sar[0]);
                    axi_resp_i.r.resp  = 2'($urandom());
                    axi_resp_i.r.last  = 1'($urandom());
                    axi_resp_i.r.id    = 4'($urandom());
                end
                if (!axi_resp_i.b_valid && ((aw_n < w_n) ? aw_n : w_n) > b_given &&
                    $urandom_range(0, 1) == 1) begin
                    axi_resp_i.b_valid = 1'b1;
                    axi_resp_i.b.resp  = 2'($urandom());
                    b_given++;
                end
                settle();

                chk("rnd_rvalid", rvalid_o, exp_rv);
                if (exp_rv) begin
                    chk("rnd_rdata", rdata_o, exp_rd);
                    chk("rnd_err", err_o, exp_err);
                    last_rd = exp_rd;
                end else chk("rnd_rdata_hold", rdata_o, last_rd);
                exp_rv = 0;

                if (mq.size() > 0) begin
                    chk("rnd_r_ready", axi_req_o.r_ready, !mq[0].we);
                    chk("rnd_b_ready", axi_req_o.b_ready, mq[0].we);
                end else chk("rnd_readys_idle", {axi_req_o.r_ready, axi_req_o.b_ready}, 0);
                if (mq.size() == MAXO) chk("rnd_gnt_full", gnt_o, 0);
                gnt_seen = gnt_o;
                if (gnt_o) begin
                    chk("rnd_gnt_req", req_i, 1);
                    mq.push_back('{we: we_i, addr: addr_i});
                    if (we_i) begin
                        eaw.push_back(addr_i);
                        ew.push_back({be_i, wdata_i});
                    end else ear.push_back(addr_i);
                end

                if (axi_req_o.ar_valid && axi_resp_i.ar_ready) begin
                    e32 = 'x;
                    if (ear.size() > 0) e32 = ear.pop_front();
                    chk("rnd_ar_addr", axi_req_o.ar.addr, e32);
                    chk("rnd_ar_size", axi_req_o.ar.size, 2);
                    sar.push_back(axi_req_o.ar.addr);
                end
                if (axi_req_o.aw_valid && axi_resp_i.aw_ready) begin
                    e32 = 'x;
                    if (eaw.size() > 0) e32 = eaw.pop_front();
                    chk("rnd_aw_addr", axi_req_o.aw.addr, e32);
                    aw_n++;
                end
                if (axi_req_o.w_valid && axi_resp_i.w_ready) begin
                    e36 = 'x;
                    if (ew.size() > 0) e36 = ew.pop_front();
                    chk("rnd_w_beat", {axi_req_o.w.strb, axi_req_o.w.data}, e36);
                    w_n++;
                end
                if (axi_req_o.r_ready && axi_resp_i.r_valid && mq.size() > 0) begin
                    exp_rv = 1; exp_rd = hash(mq[0].addr);
                    exp_err = ERR_EN & axi_resp_i.r.resp[1];
                    void'(mq.pop_front());
                    if (sar.size() > 0) void'(sar.pop_front());
                    r_clr = 1;
                end else if (axi_req_o.b_ready && axi_resp_i.b_valid && mq.size() > 0) begin
                    exp_rv = 1; exp_rd = 0;
                    exp_err = ERR_EN & axi_resp_i.b.resp[1];
                    void'(mq.pop_front());
                    b_clr = 1;
                end
            end
            chk("rnd_drained", mq.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
